// File: rtl/mem_tx_streamer_pkg.sv
// mem_tx_streamer_pkg: state encoding and default constants shared by the
// memory-to-UART streamer and its ack timer.
package mem_tx_streamer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;
    localparam logic [7:0] DEF_STOP_BYTE   = 8'h0C;
    localparam int         DEF_ACK_TIMEOUT = 15;
endpackage

// File: rtl/mem_tx_streamer_tx_ack_timer.sv
// mem_tx_streamer_tx_ack_timer: loadable saturating counter that flags once
// LIMIT enabled cycles have elapsed since the last load.
module mem_tx_streamer_tx_ack_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] r_cnt;
    // The flag is raised during the LIMIT-th enabled cycle so the caller can leave on that edge.
    assign o_expired = r_cnt >= W'(LIMIT - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (i_load) r_cnt <= '0;
        else if (i_en && !o_expired) r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/mem_tx_streamer.sv
// mem_tx_streamer: fetches LEN words from data memory starting at BASE and sends
// the low byte of each through the UART, optionally stopping at a terminator byte.
module mem_tx_streamer
    import mem_tx_streamer_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter int         LEN_W       = 8,
    parameter bit         STOP_EN     = 1'b1,
    parameter logic [7:0] STOP_BYTE   = DEF_STOP_BYTE,
    parameter int         ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  sent_count,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [31:0]       mem_q,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_busy
);
    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_rem, r_cnt;
    logic [7:0]         r_data;
    logic               r_err;
    logic               w_expired, w_accept, w_unused;

    assign w_unused   = ^mem_q[31:8];
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign busy       = r_state != ST_IDLE;
    assign done       = r_state == ST_DONE;
    assign mem_req    = r_state == ST_REQ;
    assign mem_rden   = mem_req && mem_gnt;
    assign mem_addr   = r_addr;
    assign tx_data    = r_data;
    assign tx_enable  = (r_state == ST_SEND) && !tx_busy;
    assign error      = r_err;
    assign sent_count = r_cnt;

    mem_tx_streamer_tx_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (tx_enable),
        .i_en      (r_state == ST_WAIT_HI),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = (length == '0) ? ST_DONE : ST_REQ;
            ST_REQ:     if (mem_gnt) w_next = ST_READ;
            ST_READ:    w_next = (STOP_EN && mem_q[7:0] == STOP_BYTE) ? ST_DONE : ST_SEND;
            ST_SEND:    if (!tx_busy) w_next = ST_WAIT_HI;
            ST_WAIT_HI: w_next = tx_busy ? ST_WAIT_LO : (w_expired ? ST_DONE : ST_WAIT_HI);
            ST_WAIT_LO: if (!tx_busy) w_next = (r_rem == LEN_W'(1)) ? ST_DONE : ST_REQ;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= base_addr;
                r_rem  <= length;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (r_state == ST_READ) r_data <= mem_q[7:0];
            if (r_state == ST_WAIT_HI && !tx_busy && w_expired) r_err <= 1'b1;
            if (r_state == ST_WAIT_LO && !tx_busy) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_tx_streamer.sv
// tb_mem_tx_streamer: directed and randomized transfers checked against a
// word-list model of what the streamer should read and send.
module tb_mem_tx_streamer;
    localparam logic [7:0] STOP   = 8'h0C;
    localparam int         ACK_TO = 15;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, error, mem_req, mem_gnt, mem_rden, tx_enable, tx_busy;
    logic [7:0]  base_addr, length, sent_count, mem_addr, tx_data;
    logic [31:0] mem_q;
    logic [31:0] mem [256];

    int checks = 0, failures = 0;
    int cyc_now = 0, done_cnt = 0, en_cnt = 0, req_cnt = 0, rden_cnt = 0, viol = 0;
    int en_time = 0, done_time = 0, req_run = 0, last_run = 0, addr_flip = 0;
    logic [7:0] last_addr = '0;
    logic [7:0] sent_q[$], rd_q[$];
    int s0, r0, d0, e0, q0, n0, lat;
    logic acc_err;

    int gnt_lat = 0, rnd_lat = 0, req_age = 0, u_t = 0, u_rise = 0, u_len = 10;
    logic rnd_gnt = 1'b0, rnd_ext = 1'b0, ext_busy = 1'b0, u_busy;

    always #5 clk = ~clk;

    mem_tx_streamer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .error(error), .sent_count(sent_count),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_q(mem_q), .tx_data(tx_data), .tx_enable(tx_enable), .tx_busy(tx_busy)
    );

    // Arbiter: grant after a configurable number of waiting cycles.
    assign mem_gnt = mem_req && (req_age >= (rnd_gnt ? rnd_lat : gnt_lat));
    always @(posedge clk) begin
        req_age <= (mem_req && !mem_gnt) ? req_age + 1 : 0;
        if (mem_rden) begin
            mem_q   <= mem[mem_addr];
            rnd_lat <= $urandom_range(0, 3);
        end
    end

    // UART: busy for u_len cycles, starting u_rise cycles after each enable.
    assign u_busy  = (u_t > u_rise) && (u_t <= u_rise + u_len);
    assign tx_busy = u_busy || ext_busy;
    always @(posedge clk or negedge rst) begin
        if (!rst) u_t <= 0;
        else if (tx_enable) u_t <= 1;
        else if (u_t > 0 && u_t <= u_rise + u_len) u_t <= u_t + 1;
        else u_t <= 0;
    end
    always @(negedge clk) ext_busy = rnd_ext && ($urandom_range(0, 9) == 0);

    always @(posedge clk) begin
        cyc_now++;
        if (rst) begin
            if (tx_enable) begin
                sent_q.push_back(tx_data);
                en_cnt++;
                en_time = cyc_now;
                if (tx_busy) viol++;
            end
            if (done) begin
                done_cnt++;
                done_time = cyc_now;
            end
            if (mem_req) req_cnt++;
            if (mem_rden) begin
                rd_q.push_back(mem_addr);
                rden_cnt++;
                last_run = req_run + 1;
                req_run = 0;
            end else if (mem_req) begin
                if (req_run > 0 && mem_addr != last_addr) addr_flip++;
                req_run++;
            end
            last_addr = mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic [7:0] l);
        s0 = sent_q.size(); r0 = rd_q.size(); d0 = done_cnt; e0 = en_cnt; q0 = req_cnt; n0 = rden_cnt;
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0; lat = 1; acc_err = error;
        while (!done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    task automatic compare(input string t, input logic [7:0] b, input logic [7:0] l, input logic exp_err);
        logic [7:0] eb[$], ea[$], a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 8'(i);
            ea.push_back(a);
            if (mem[a][7:0] == STOP) break;
            eb.push_back(mem[a][7:0]);
        end
        chk({t, "_nsent"}, sent_q.size() - s0, eb.size());
        foreach (eb[i]) if (s0 + i < sent_q.size()) chk({t, "_byte"}, sent_q[s0 + i], eb[i]);
        chk({t, "_nread"}, rd_q.size() - r0, ea.size());
        foreach (ea[i]) if (r0 + i < rd_q.size()) chk({t, "_addr"}, rd_q[r0 + i], ea[i]);
        chk({t, "_sent_count"}, sent_count, eb.size());
        chk({t, "_done_pulses"}, done_cnt - d0, 1);
        chk({t, "_error"}, error, exp_err);
        chk({t, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
        chk("rst_mem_req", mem_req, 0); chk("rst_mem_rden", mem_rden, 0); chk("rst_tx_enable", tx_enable, 0);
        chk("rst_sent_count", sent_count, 0); chk("rst_mem_addr", mem_addr, 0); chk("rst_tx_data", tx_data, 0);
        rst = 1'b1;
        @(negedge clk);

        mem[8'h10] = 32'h1234_5641; mem[8'h11] = 32'hFFFF_FF42; mem[8'h12] = 32'h0000_0043;
        xfer(8'h10, 8'd3);
        compare("basic", 8'h10, 8'd3, 1'b0);
        chk("basic_enables", en_cnt - e0, 3);

        xfer(8'h55, 8'd0);
        chk("len0_latency", lat, 1);
        chk("len0_no_req", req_cnt - q0, 0);
        compare("len0", 8'h55, 8'd0, 1'b0);

        mem[8'h20] = 32'h0000_0048; mem[8'h21] = 32'h0000_000C; mem[8'h22] = 32'h0000_0049;
        xfer(8'h20, 8'd3);
        compare("stop", 8'h20, 8'd3, 1'b0);
        chk("stop_sent_count", sent_count, 1);

        gnt_lat = 7; addr_flip = 0;
        xfer(8'h30, 8'd1);
        chk("gnt_req_run", last_run, 8);
        chk("gnt_addr_stable", addr_flip, 0);
        chk("gnt_rden_pulses", rden_cnt - n0, 1);
        compare("gnt", 8'h30, 8'd1, 1'b0);
        gnt_lat = 0;

        u_len = 0;
        xfer(8'h40, 8'd2);
        chk("to_error", error, 1'b1);
        chk("to_latency", done_time - en_time, ACK_TO + 1);
        chk("to_sent_count", sent_count, 0);
        chk("to_enables", en_cnt - e0, 1);
        u_len = 10;
        xfer(8'h40, 8'd1);
        chk("to_cleared_on_start", acc_err, 1'b0);
        compare("after_to", 8'h40, 8'd1, 1'b0);

        xfer(8'hFE, 8'd3);
        compare("wrap", 8'hFE, 8'd3, 1'b0);

        e0 = en_cnt; d0 = done_cnt;
        start = 1'b1; base_addr = 8'hFE; length = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && en_cnt == e0; i++) @(negedge clk);
        chk("midrst_first_send", en_cnt - e0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0); chk("midrst_done", done, 0); chk("midrst_mem_req", mem_req, 0);
        chk("midrst_tx_enable", tx_enable, 0); chk("midrst_sent_count", sent_count, 0);
        chk("midrst_mem_addr", mem_addr, 0); chk("midrst_tx_data", tx_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_more_enable", en_cnt - e0, 1);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);

        rnd_gnt = 1'b1; rnd_ext = 1'b1;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b, l;
            for (int i = 0; i < 256; i++) begin
                mem[i] = $urandom;
                if ($urandom_range(0, 7) == 0) mem[i][7:0] = STOP;
            end
            b = 8'($urandom); l = 8'($urandom_range(0, 6));
            u_rise = $urandom_range(0, 2); u_len = $urandom_range(1, 6);
            xfer(b, l);
            compare("rnd", b, l, 1'b0);
        end
        rnd_ext = 1'b0;
        repeat (20) @(negedge clk);

        chk("enable_while_busy", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
